shwr_area_capture: RTL and testbench
====================================

Name: shwr_area_capture

Overview:
- Downstream consumer of the per-channel shower integral stage. Latches the settled integral, peak, baseline and saturation results once per trigger and queues them as one record each.
- Records go into a small FIFO for the processor-side readout logic, at most one record per trigger.
- Also supplies sequence numbering, truncation flagging and FIFO overflow accounting.

Parameters:
- SETTLE_CYCLES, 264, cycles after the TRIGGERED rising edge before results are final (area window plus integrator pipeline). Range 1..4095.
- FIFO_DEPTH_LOG2, 4, log2 of record FIFO depth (default 16 records).
- SEQ_WIDTH, 8, width of record sequence counter.

Ports:
- CLK120  in  1  system clock, 120 MHz.
- RESET  in  1  asynchronous, active-high reset.
- TRIGGERED  in  1  trigger window active, synchronous to CLK120.
- INTEGRAL  in  `SHWR_AREA_WIDTH  running integral from the integral stage.
- PEAK  in  `ADC_WIDTH  baseline-subtracted peak.
- BASELINE  in  `ADC_WIDTH+`SHWR_BASELINE_EXTRA_BITS  pre-trigger baseline.
- SATURATED  in  1  saturation flag.
- RD_EN  in  1  single-cycle pop request from readout.
- REC_VALID  out  1  FIFO non-empty; REC_DATA holds head record.
- REC_DATA  out  REC_WIDTH  head record, fields packed MSB→LSB: SEQ, TRUNC, SATURATED, BASELINE, PEAK, INTEGRAL.
- REC_COUNT  out  FIFO_DEPTH_LOG2+1  records held.
- OVERFLOW  out  1  sticky: a record was dropped because the FIFO was full.
- DROP_COUNT  out  16  dropped-record count, saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync deassert on CLK120):
  - State IDLE.
  - FIFO empty. REC_VALID=0, REC_DATA=0, REC_COUNT=0.
  - OVERFLOW=0, DROP_COUNT=0, SEQ=0, settle counter=0.
- FSM states IDLE, SETTLE, CAPTURE, WAIT_LOW:
  - IDLE: TRIGGERED rising edge (registered previous value 0, current value 1) → SETTLE, counter loaded with 1.
  - SETTLE: counter increments each cycle. Counter==SETTLE_CYCLES → CAPTURE with TRUNC=0. TRIGGERED drops first → CAPTURE with TRUNC=1. The inputs sampled are the ones in the same cycle as the exit condition.
  - CAPTURE (one cycle): write record {SEQ, TRUNC, SATURATED, BASELINE, PEAK, INTEGRAL}; SEQ increments modulo 2^SEQ_WIDTH, wrapping 255→0 silently. Next state: WAIT_LOW if TRIGGERED=1, else IDLE.
  - WAIT_LOW: stay until TRIGGERED=0, then go to IDLE. A new rising edge needs a 0 then a 1 observed from IDLE.
- Latency:
  - Record is visible at the FIFO head the cycle after CAPTURE.
  - REC_VALID rises that same cycle if the FIFO was empty.
- FIFO:
  - Registered head (first-word-fall-through). REC_DATA is stable while REC_VALID=1 and RD_EN=0.
  - RD_EN while empty is ignored. No pointer movement and no error.
- Full FIFO at CAPTURE:
  - Record is dropped. OVERFLOW←1 (sticky until RESET). DROP_COUNT increments, saturating.
  - SEQ still increments, so the readout sees the gap.
- Simultaneous RD_EN and CAPTURE write:
  - Empty FIFO: write lands and REC_VALID=1; the RD_EN is ignored.
  - Full FIFO: pop happens first, write succeeds, no drop, count unchanged.
  - Otherwise: count is unchanged and both operations complete.
- Pointers are FIFO_DEPTH_LOG2 bits and wrap naturally. Full and empty are derived from REC_COUNT.
- RESET mid-SETTLE or mid-FIFO: everything clears immediately and the partial record is discarded.
- Input widths pass through unchanged; no arithmetic on data fields.

Optional Feature:
- Macro SHWR_AREA_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter (reset 0, wraps) is sampled on the TRIGGERED rising edge.
  - The sample is appended as the most-significant REC_DATA field, and REC_WIDTH grows by 32.
- Undefined: no counter is built and the record layout is as listed above.

Decomposition:
- Shared package/defines header:
  - REC_WIDTH expression and field offsets.
  - FSM state encodings (2-bit).
  - SHWR_CAPTURE_DROP_WIDTH=16.
- One sub-module: shwr_rec_fifo, a parameterised synchronous FWFT FIFO with write, read, count and full/empty. The FSM and accounting stay in the top.

Test Plan:
- SETTLE_CYCLES=8; TRIGGERED high 20 cycles with INTEGRAL=1234, PEAK=600, BASELINE=1000, SATURATED=0 → one record, SEQ=0, TRUNC=0, fields match; REC_VALID 1 cycle after CAPTURE; RD_EN pop → REC_VALID=0.
- TRIGGERED high 5 cycles (<8) with INTEGRAL=77 → record TRUNC=1, INTEGRAL=77 (value sampled in the drop cycle).
- 18 triggers with no reads, depth 16 → REC_COUNT=16, OVERFLOW=1, DROP_COUNT=2; popped SEQ values 0..15.
- FIFO full, RD_EN asserted in the CAPTURE cycle → no drop, REC_COUNT stays 16, newest SEQ stored.
- 260 triggers → SEQ wraps 255→0; RESET asserted mid-SETTLE → all outputs 0 asynchronously; the next trigger gives SEQ=0.
- With SHWR_AREA_TIMESTAMP_EN: trigger edges at cycles 100 and 400 after reset → timestamps differ by 300.

Source files
------------

// File: rtl/shwr_area_capture_pkg.sv
// +------------------------------------------------------------------------+
// | shwr_area_capture_pkg : record layout, FSM encoding, shared widths       |
// | Optional macro: SHWR_AREA_TIMESTAMP_EN.   Revision: 1.0                  |
// +------------------------------------------------------------------------+
`ifndef SHWR_AREA_WIDTH
`define SHWR_AREA_WIDTH 24
`endif
`ifndef ADC_WIDTH
`define ADC_WIDTH 12
`endif
`ifndef SHWR_BASELINE_EXTRA_BITS
`define SHWR_BASELINE_EXTRA_BITS 3
`endif
`default_nettype none

package shwr_area_capture_pkg;

  localparam int INTEGRAL_W   = `SHWR_AREA_WIDTH;
  localparam int PEAK_W       = `ADC_WIDTH;
  localparam int BASELINE_W   = `ADC_WIDTH + `SHWR_BASELINE_EXTRA_BITS;

  localparam int INTEGRAL_LSB = 0;
  localparam int PEAK_LSB     = INTEGRAL_LSB + INTEGRAL_W;
  localparam int BASELINE_LSB = PEAK_LSB + PEAK_W;
  localparam int SAT_BIT      = BASELINE_LSB + BASELINE_W;
  localparam int TRUNC_BIT    = SAT_BIT + 1;
  localparam int SEQ_LSB      = TRUNC_BIT + 1;

`ifdef SHWR_AREA_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif

  localparam int SHWR_CAPTURE_DROP_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_WAIT_LOW = 2'd3
  } cap_state_t;

  function automatic int rec_width(input int seq_w);
    return SEQ_LSB + seq_w + TS_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shwr_rec_fifo.sv
// +------------------------------------------------------------------------+
// | shwr_rec_fifo : synchronous first-word-fall-through record FIFO          |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
`default_nettype none

module shwr_rec_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == FULL_CNT);
  assign count  = r_count;
  assign w_pop  = rd_en & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign w_push = wr_en & (~full | rd_en);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/shwr_area_capture.sv
// +------------------------------------------------------------------------+
// | shwr_area_capture : latches settled shower results once per trigger      |
// | Optional macro: SHWR_AREA_TIMESTAMP_EN.   Revision: 1.0                  |
// +------------------------------------------------------------------------+
`default_nettype none

module shwr_area_capture
  import shwr_area_capture_pkg::*;
#(
  parameter  int SETTLE_CYCLES   = 264,
  parameter  int FIFO_DEPTH_LOG2 = 4,
  parameter  int SEQ_WIDTH       = 8,
  localparam int REC_WIDTH       = rec_width(SEQ_WIDTH)
) (
  input  logic                               CLK120,
  input  logic                               RESET,
  input  logic                               TRIGGERED,
  input  logic [`SHWR_AREA_WIDTH-1:0]        INTEGRAL,
  input  logic [`ADC_WIDTH-1:0]              PEAK,
  input  logic [`ADC_WIDTH+`SHWR_BASELINE_EXTRA_BITS-1:0] BASELINE,
  input  logic                               SATURATED,
  input  logic                               RD_EN,
  output logic                               REC_VALID,
  output logic [REC_WIDTH-1:0]               REC_DATA,
  output logic [FIFO_DEPTH_LOG2:0]           REC_COUNT,
  output logic                               OVERFLOW,
  output logic [SHWR_CAPTURE_DROP_WIDTH-1:0] DROP_COUNT
);

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

  cap_state_t                         r_state;
  cap_state_t                         w_state_nxt;
  logic                               r_trig_d;
  logic [CNT_W-1:0]                   r_cnt;
  logic [CNT_W-1:0]                   w_cnt_nxt;
  logic [SEQ_LSB-1:0]                 r_payload;
  logic [SEQ_WIDTH-1:0]               r_seq;
  logic                               r_overflow;
  logic [SHWR_CAPTURE_DROP_WIDTH-1:0] r_drop_cnt;
  logic                               w_rise;
  logic                               w_latch;
  logic                               w_trunc;
  logic                               w_wr_en;
  logic                               w_drop;
  logic                               w_full;
  logic                               w_empty;
  logic [REC_WIDTH-1:0]               w_rec;

  assign w_rise = TRIGGERED & ~r_trig_d;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_trunc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        // Reaching the settle count wins over a simultaneous trigger drop.
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_CAPTURE;
          w_latch     = 1'b1;
        end else if (!TRIGGERED) begin
          w_state_nxt = ST_CAPTURE;
          w_latch     = 1'b1;
          w_trunc     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_CAPTURE:  w_state_nxt = TRIGGERED ? ST_WAIT_LOW : ST_IDLE;
      ST_WAIT_LOW: if (!TRIGGERED) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_wr_en = (r_state == ST_CAPTURE);
  assign w_drop  = w_wr_en & w_full & ~RD_EN;

  always_ff @(posedge CLK120 or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_trig_d   <= 1'b0;
      r_cnt      <= '0;
      r_payload  <= '0;
      r_seq      <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_trig_d <= TRIGGERED;
      r_cnt    <= w_cnt_nxt;
      if (w_latch) r_payload <= {w_trunc, SATURATED, BASELINE, PEAK, INTEGRAL};
      // Dropped records still consume a sequence number so readout sees the gap.
      if (w_wr_en) r_seq <= r_seq + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

`ifdef SHWR_AREA_TIMESTAMP_EN
  logic [31:0] r_cycle;
  logic [31:0] r_ts;

  always_ff @(posedge CLK120 or posedge RESET) begin
    if (RESET) begin
      r_cycle <= '0;
      r_ts    <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      if (r_state == ST_IDLE && w_rise) r_ts <= r_cycle;
    end
  end

  assign w_rec = {r_ts, r_seq, r_payload};
`else
  assign w_rec = {r_seq, r_payload};
`endif

  shwr_rec_fifo #(
    .WIDTH      (REC_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (CLK120),
    .rst     (RESET),
    .wr_en   (w_wr_en),
    .wr_data (w_rec),
    .rd_en   (RD_EN),
    .rd_data (REC_DATA),
    .count   (REC_COUNT),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign REC_VALID  = ~w_empty;
  assign OVERFLOW   = r_overflow;
  assign DROP_COUNT = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_shwr_area_capture.sv
// +------------------------------------------------------------------------+
// | tb_shwr_area_capture : scoreboard bench for shwr_area_capture            |
// | Optional macro: SHWR_AREA_TIMESTAMP_EN.   Revision: 1.0                  |
// +------------------------------------------------------------------------+
`ifndef SHWR_AREA_WIDTH
`define SHWR_AREA_WIDTH 24
`endif
`ifndef ADC_WIDTH
`define ADC_WIDTH 12
`endif
`ifndef SHWR_BASELINE_EXTRA_BITS
`define SHWR_BASELINE_EXTRA_BITS 3
`endif
`default_nettype none

module tb_shwr_area_capture;

  localparam int SETTLE = 8;
  localparam int DEPTH  = 16;
  localparam int SW     = 8;
  localparam int IW     = `SHWR_AREA_WIDTH;
  localparam int PKW    = `ADC_WIDTH;
  localparam int BW     = `ADC_WIDTH + `SHWR_BASELINE_EXTRA_BITS;
  localparam int PW     = IW + PKW + BW + 2;
`ifdef SHWR_AREA_TIMESTAMP_EN
  localparam int RW = PW + SW + 32;
`else
  localparam int RW = PW + SW;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           trig;
  logic [IW-1:0]  integ;
  logic [PKW-1:0] peak;
  logic [BW-1:0]  baseline;
  logic           sat;
  logic           rd_en;
  logic           rec_valid;
  logic [RW-1:0]  rec_data;
  logic [4:0]     rec_count;
  logic           overflow;
  logic [15:0]    drop_count;

  logic [PW+SW-1:0] exp_q[$];
  logic [31:0]      ts_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int m_seq  = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  shwr_area_capture #(
    .SETTLE_CYCLES   (SETTLE),
    .FIFO_DEPTH_LOG2 (4),
    .SEQ_WIDTH       (SW)
  ) dut (
    .CLK120     (clk),
    .RESET      (rst),
    .TRIGGERED  (trig),
    .INTEGRAL   (integ),
    .PEAK       (peak),
    .BASELINE   (baseline),
    .SATURATED  (sat),
    .RD_EN      (rd_en),
    .REC_VALID  (rec_valid),
    .REC_DATA   (rec_data),
    .REC_COUNT  (rec_count),
    .OVERFLOW   (overflow),
    .DROP_COUNT (drop_count)
  );

  function automatic logic [PW+SW-1:0] mk(input int seq, input bit tr, input bit s,
                                          input int bl, input int pk, input int ig);
    logic [SW-1:0]  f_seq;
    logic [BW-1:0]  f_b;
    logic [PKW-1:0] f_p;
    logic [IW-1:0]  f_i;
    f_seq = SW'(seq);
    f_b   = BW'(bl);
    f_p   = PKW'(pk);
    f_i   = IW'(ig);
    return {f_seq, tr, s, f_b, f_p, f_i};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic monitor_loop();
    logic [PW+SW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rd_en && rec_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_record: actual=%0h required=<none>", rec_data);
        end else begin
          e = exp_q.pop_front();
          check("rec_data", rec_data[PW+SW-1:0], e);
`ifdef SHWR_AREA_TIMESTAMP_EN
          ts_q.push_back(rec_data[RW-1 -: 32]);
`endif
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_seq = 0;
    m_cnt = 0;
  endtask

  // Record expectation is queued before the trigger; ig_lo is driven from the drop cycle on.
  task automatic trigger(input int len, input int gap, input bit tr, input int ig_hi,
                         input int ig_lo, input int pk, input int bl, input bit s,
                         input bit rd_cap);
    integ    = IW'(ig_hi);
    peak     = PKW'(pk);
    baseline = BW'(bl);
    sat      = s;
    if (m_cnt < DEPTH || rd_cap) begin
      exp_q.push_back(mk(m_seq, tr, s, bl, pk, tr ? ig_lo : ig_hi));
      if (!rd_cap) m_cnt++;
    end
    m_seq = (m_seq + 1) % 256;
    trig = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (rd_cap && i == SETTLE + 1) rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    trig  = 1'b0;
    integ = IW'(ig_lo);
    repeat (gap) tick();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (rec_valid && g < DEPTH + 4) begin
      rd_en = 1'b1;
      tick();
      g++;
    end
    rd_en = 1'b0;
    m_cnt = 0;
    check("drain_valid", rec_valid, 0);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor_loop();
    join_none

    rst = 1'b1; trig = 1'b0; integ = '0; peak = '0; baseline = '0; sat = 1'b0; rd_en = 1'b0;
    repeat (3) tick();
    check("reset_valid", rec_valid, 0);
    check("reset_data", rec_data, 0);
    check("reset_count", rec_count, 0);
    check("reset_overflow", overflow, 0);
    check("reset_drop", drop_count, 0);
    rst = 1'b0;
    tick();

    // Basic record and one-cycle-after-CAPTURE latency
    integ = IW'(1234); peak = PKW'(600); baseline = BW'(1000); sat = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 1000, 600, 1234));
    m_seq = 1; m_cnt = 1;
    trig = 1'b1;
    repeat (9) tick();
    check("valid_in_capture", rec_valid, 0);
    tick();
    check("valid_after_capture", rec_valid, 1);
    check("count_one", rec_count, 1);
    repeat (10) tick();
    trig = 1'b0;
    repeat (3) tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    m_cnt = 0;
    check("valid_after_pop", rec_valid, 0);

    // Truncated window samples the drop-cycle inputs; full window samples settle-cycle inputs
    trigger(5, 4, 1, 55, 77, 4095, 32767, 1, 0);
    drain();
    trigger(12, 3, 0, 9999, 1, 0, 0, 0, 0);
    drain();

    // Overflow: 18 triggers into 16 slots
    do_reset();
    for (int i = 0; i < 18; i++) trigger(10, 3, 0, 100 + i, 5, i, 2 * i, i[0], 0);
    check("full_count", rec_count, 16);
    check("overflow_set", overflow, 1);
    check("drop_two", drop_count, 2);

    // Pop in the CAPTURE cycle of a full FIFO: no drop
    trigger(10, 3, 0, 4321, 6, 7, 8, 0, 1);
    check("full_pop_write_count", rec_count, 16);
    check("full_pop_write_drop", drop_count, 2);
    drain();

    // Pop while empty is ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_pop_count", rec_count, 0);
    trigger(10, 3, 0, 11, 0, 22, 33, 1, 0);
    check("after_empty_pop_count", rec_count, 1);
    drain();

    // Sequence wrap 255 -> 0
    for (int i = 0; i < 240; i++) begin
      trigger(10, 3, 0, i * 37, 0, i, i * 3, i[0], 0);
      drain();
    end

    // Asynchronous reset in the middle of SETTLE with a record pending
    trigger(10, 3, 0, 5, 0, 5, 5, 0, 0);
    trig = 1'b1;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", rec_valid, 0);
    check("async_rst_data", rec_data, 0);
    check("async_rst_count", rec_count, 0);
    check("async_rst_overflow", overflow, 0);
    check("async_rst_drop", drop_count, 0);
    trig = 1'b0;
    exp_q.delete();
    m_seq = 0;
    m_cnt = 0;
    tick();
    rst = 1'b0;
    tick();
    trigger(10, 3, 0, 606, 0, 60, 6, 0, 0);
    drain();

`ifdef SHWR_AREA_TIMESTAMP_EN
    do_reset();
    ts_q.delete();
    repeat (98) tick();
    trigger(10, 290, 0, 1, 0, 2, 3, 0, 0);
    trigger(10, 3, 0, 4, 0, 5, 6, 0, 0);
    drain();
    check("ts_count", ts_q.size(), 2);
    if (ts_q.size() == 2) check("ts_delta", ts_q[1] - ts_q[0], 300);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
